seq_mult_ctrl: RTL and testbench
================================

Name: seq_mult_ctrl

Overview:
- Sequential shift-add multiplier controller for the arithmetic teaching datapath.
- Sequences one W-bit AND-gated partial-product stage and one adder over W cycles to form an unsigned 2W-bit product.
- A start/busy/done handshake lets a CPU control unit or testbench issue one multiply at a time.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  WIDTH  multiplicand, unsigned; captured when start is accepted
- b  input  WIDTH  multiplier, unsigned; captured when start is accepted
- busy  output  1  high while state is not IDLE
- done  output  1  one-cycle pulse; product is valid in this cycle
- product  output  2*WIDTH  last completed result; held until the next completion

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous and active-low.
- Reset while rst_n=0 (asynchronous assert):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal multiplicand, multiplier, accumulator and counter all cleared.
  - Reset deassertion is used synchronously.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at a rising edge: latch mcand<=a, mplier<=b, acc<=0 (2*WIDTH+1 bits incl. carry), cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, every cycle:
  - partial = mcand AND {WIDTH{mplier[0]}}, a bitwise AND per bit.
  - sum = acc[2W-1:W] + partial, WIDTH+1 bits; the carry is kept.
  - acc <= {sum, acc[W-1:0]} >> 1, a logical right shift of the full W+1+W concatenation.
  - mplier <= mplier >> 1; cnt <= cnt+1.
  - When cnt==WIDTH-1, the next state is DONE. Exactly WIDTH RUN cycles are executed.
- DONE:
  - The product register loads acc[2W-1:0] on the edge entering DONE.
  - done=1 for exactly one cycle; the next edge returns to IDLE.
- busy = (state != IDLE), registered-state decode.
- Latency, for start sampled at edge k:
  - busy is high in the cycles after edges k through k+WIDTH.
  - done and the new product appear in the cycle after edge k+WIDTH.
  - busy and done drop after edge k+WIDTH+1.
  - Total is WIDTH+1 cycles from acceptance to IDLE.
- start in RUN or DONE is ignored, with no queueing. The earliest new acceptance is at edge k+WIDTH+2.
- a and b may change freely after acceptance; the result uses only the captured values.
- product is stable outside the DONE-entry edge; it is never cleared except by reset.
- No overflow is possible: the 2W-bit result is exact for all unsigned inputs.
- Reset during RUN or DONE: immediate return to IDLE with all outputs 0. The aborted result is lost, and no done pulse is issued.
- The counter is wide enough to hold WIDTH-1 (clog2(WIDTH) bits, minimum 1).

Test Plan:
- WIDTH=8, a=13, b=11, start pulsed one cycle -> busy high 9 cycles; done pulse after edge k+8 with product=143; product still 143 ten cycles later.
- WIDTH=8 extremes -> 255*255 gives 65025 (0xFE01); 0*200 gives 0; 1*255 gives 255; 128*2 gives 256; each completes in 9 cycles.
- start held high continuously with a=7, b=9, then a changed to 3 mid-operation:
  - first result 63;
  - start ignored during RUN and DONE;
  - the second operation is accepted at edge k+10 with the then-current a.
- Reset mid-RUN: rst_n low 2 cycles after acceptance (between edges) -> busy=0, done=0, product=0 asynchronously; no done pulse after release.
- Reset re-entry: after release, 6*6 -> product=36 in 9 cycles.
- WIDTH=4 instance -> 15*15 gives 225; 9*5 gives 45; done after edge k+4; busy high 5 cycles.
- Random regression: 1000 random a,b pairs with back-to-back starts -> every product equals the unsigned a*b reference; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add unsigned multiplier: one AND-gated partial product and
// one adder per cycle, WIDTH cycles per multiply, start/busy/done handshake.
module seq_mult_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_partial;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  // The multiplier rides in the low half of acc: each shift retires its LSB
  // as a product bit moves in, so the carry bit of the wide shift is never set.
  always_comb begin
    w_partial  = r_mcand & {WIDTH{r_acc[0]}};
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_partial};
    w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    w_last     = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_product <= w_acc_next;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: WIDTH=8 and WIDTH=4 instances checked each cycle
// against a timing/arithmetic model, plus directed literal expectations.
module tb_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mult_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  seq_mult_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted start occupies WIDTH+1 cycles; the last one is the done cycle.
  int unsigned m8_left = 0, m4_left = 0;
  logic [15:0] m8_op = '0, m8_prod = '0;
  logic [7:0]  m4_op = '0, m4_prod = '0;
  int m8_done_exp = 0, m4_done_exp = 0;
  int done8_cnt = 0, done4_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_left <= 0;
      m8_prod <= '0;
    end else if (m8_left != 0) begin
      m8_left <= m8_left - 1;
      if (m8_left == 2) begin
        m8_prod     <= m8_op;
        m8_done_exp <= m8_done_exp + 1;
      end
    end else if (start8) begin
      m8_left <= 9;
      m8_op   <= 16'(a8) * 16'(b8);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_left <= 0;
      m4_prod <= '0;
    end else if (m4_left != 0) begin
      m4_left <= m4_left - 1;
      if (m4_left == 2) begin
        m4_prod     <= m4_op;
        m4_done_exp <= m4_done_exp + 1;
      end
    end else if (start4) begin
      m4_left <= 5;
      m4_op   <= 8'(a4) * 8'(b4);
    end
  end

  always @(negedge clk) begin
    chk("busy8", busy8, m8_left != 0);
    chk("done8", done8, m8_left == 1);
    chk("prod8", prod8, m8_prod);
    chk("busy4", busy4, m4_left != 0);
    chk("done4", done4, m4_left == 1);
    chk("prod4", prod4, m4_prod);
    if (done8) done8_cnt++;
    if (done4) done4_cnt++;
  end

  task automatic run_op(input bit w4, input int unsigned av, input int unsigned bv,
                        input int unsigned expv);
    int c = 0;
    if (w4) begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
    else    begin a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1; end
    do begin
      @(negedge clk);
      c++;
      if (c == 1) begin start4 = 1'b0; start8 = 1'b0; end
    end while (!(w4 ? done4 : done8) && c < 40);
    chk($sformatf("latency_w%0d_%0dx%0d", w4 ? 4 : 8, av, bv), c, w4 ? 5 : 9);
    chk($sformatf("product_w%0d_%0dx%0d", w4 ? 4 : 8, av, bv), w4 ? prod4 : prod8, expv);
    @(negedge clk);
  endtask

  task automatic rand8(input int n);
    int g;
    start8 = 1'b1;
    for (int i = 0; i < n; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      g = 0;
      do begin @(negedge clk); g++; end while (!done8 && g < 30);
      chk("rand8_timeout", g, 9);
      @(negedge clk);
    end
    start8 = 1'b0;
  endtask

  task automatic rand4(input int n);
    int g;
    start4 = 1'b1;
    for (int i = 0; i < n; i++) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      g = 0;
      do begin @(negedge clk); g++; end while (!done4 && g < 30);
      chk("rand4_timeout", g, 5);
      @(negedge clk);
    end
    start4 = 1'b0;
  endtask

  initial begin
    int c;
    int base8, base4;

    @(negedge clk);
    chk("reset_busy", busy8, 1'b0);
    chk("reset_done", done8, 1'b0);
    chk("reset_prod", prod8, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 13, 11, 143);
    repeat (10) @(negedge clk);
    chk("prod_held_143", prod8, 16'd143);

    run_op(1'b0, 255, 255, 65025);
    run_op(1'b0, 0, 200, 0);
    run_op(1'b0, 1, 255, 255);
    run_op(1'b0, 128, 2, 256);

    // start held high; a changes while the first multiply is running
    a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
    c = 0;
    repeat (3) begin @(negedge clk); c++; end
    a8 = 8'd3;
    while (!done8 && c < 40) begin @(negedge clk); c++; end
    chk("held_latency", c, 9);
    chk("held_prod_63", prod8, 16'd63);
    @(negedge clk);
    chk("held_ignored_in_done", busy8, 1'b0);
    @(negedge clk);
    chk("held_reaccept", busy8, 1'b1);
    start8 = 1'b0;
    c = 1;
    while (!done8 && c < 40) begin @(negedge clk); c++; end
    chk("held2_latency", c, 9);
    chk("held2_prod_27", prod8, 16'd27);
    @(negedge clk);

    // asynchronous reset in the middle of RUN
    a8 = 8'd5; b8 = 8'd5; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy8, 1'b0);
    chk("async_done", done8, 1'b0);
    chk("async_prod", prod8, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base8 = done8_cnt;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", done8_cnt - base8, 0);
    run_op(1'b0, 6, 6, 36);

    run_op(1'b1, 15, 15, 225);
    run_op(1'b1, 9, 5, 45);

    base8 = done8_cnt;
    base4 = done4_cnt;
    fork
      rand8(1000);
      rand4(300);
    join
    repeat (3) @(negedge clk);
    chk("rand8_done_count", done8_cnt - base8, 1000);
    chk("rand4_done_count", done4_cnt - base4, 300);
    chk("done8_total", done8_cnt, m8_done_exp);
    chk("done4_total", done4_cnt, m4_done_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
